// File: rtl/mem_access.sv
// MEM stage: passes EX/MEM results to writeback and runs loads/stores on a single-outstanding ack bus.
// Latency: 0 cycles for non-memory ops, 1+N stall cycles then a DONE cycle for memory ops; stallreq_o freezes upstream until ack.
module mem_access (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  wd_i,
   input  logic        wreg_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] hi_i,
   input  logic [31:0] lo_i,
   input  logic        whilo_i,
   input  logic [7:0]  aluop_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] reg2_i,
   output logic [4:0]  wd_o,
   output logic        wreg_o,
   output logic [31:0] wdata_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        whilo_o,
   output logic        mem_ce_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [3:0]  mem_sel_o,
   output logic [31:0] mem_data_o,
   input  logic [31:0] mem_data_i,
   input  logic        mem_ack_i,
   output logic        stallreq_o
);

   localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
   localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
   localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
   localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
   localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
   localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
   localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
   localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t      r_state;
   logic [31:0] r_rdata;

   logic        w_is_load;
   logic        w_is_store;
   logic        w_is_mem;
   logic        w_access;
   logic [3:0]  w_sel;
   logic [31:0] w_sdata;
   logic [31:0] w_ldata;

   always_comb begin
      w_is_load  = 1'b0;
      w_is_store = 1'b0;
      w_sel      = 4'b0000;
      w_sdata    = 32'h0;
      case (aluop_i)
         EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: begin
            w_is_load  = (aluop_i != EXE_SB_OP);
            w_is_store = (aluop_i == EXE_SB_OP);
            w_sel      = 4'b1000 >> mem_addr_i[1:0];
            w_sdata    = {4{reg2_i[7:0]}};
         end
         EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: begin
            w_is_load  = (aluop_i != EXE_SH_OP);
            w_is_store = (aluop_i == EXE_SH_OP);
            w_sel      = mem_addr_i[1] ? 4'b0011 : 4'b1100;
            w_sdata    = {2{reg2_i[15:0]}};
         end
         EXE_LW_OP, EXE_SW_OP: begin
            w_is_load  = (aluop_i == EXE_LW_OP);
            w_is_store = (aluop_i == EXE_SW_OP);
            w_sel      = 4'b1111;
            w_sdata    = reg2_i;
         end
         default: ;
      endcase
   end

   // Big-endian lanes: address offset 0 lives in bits 31:24.
   always_comb begin
      w_ldata = r_rdata;
      case (aluop_i)
         EXE_LB_OP, EXE_LBU_OP: begin
            case (mem_addr_i[1:0])
               2'b00:   w_ldata = {24'h0, r_rdata[31:24]};
               2'b01:   w_ldata = {24'h0, r_rdata[23:16]};
               2'b10:   w_ldata = {24'h0, r_rdata[15:8]};
               default: w_ldata = {24'h0, r_rdata[7:0]};
            endcase
            if (aluop_i == EXE_LB_OP)
               w_ldata[31:8] = {24{w_ldata[7]}};
         end
         EXE_LH_OP, EXE_LHU_OP: begin
            w_ldata = {16'h0, mem_addr_i[1] ? r_rdata[15:0] : r_rdata[31:16]};
            if (aluop_i == EXE_LH_OP)
               w_ldata[31:16] = {16{w_ldata[15]}};
         end
         default: ;
      endcase
   end

   assign w_is_mem = w_is_load | w_is_store;
   assign w_access = w_is_mem && (r_state != S_DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_rdata <= 32'h0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_is_mem) begin
                  if (mem_ack_i) begin
                     r_rdata <= mem_data_i;
                     r_state <= S_DONE;
                  end else begin
                     r_state <= S_BUSY;
                  end
               end
            end
            S_BUSY: begin
               if (mem_ack_i) begin
                  r_rdata <= mem_data_i;
                  r_state <= S_DONE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign wd_o       = wd_i;
   assign hi_o       = hi_i;
   assign lo_o       = lo_i;
   assign wreg_o     = wreg_i & ~w_access;
   assign whilo_o    = whilo_i & ~w_access;
   assign wdata_o    = (r_state == S_DONE && w_is_load) ? w_ldata : wdata_i;
   assign mem_ce_o   = w_access;
   assign mem_we_o   = w_access & w_is_store;
   assign mem_addr_o = w_access ? {mem_addr_i[31:2], 2'b00} : 32'h0;
   assign mem_sel_o  = w_access ? w_sel : 4'b0000;
   assign mem_data_o = (w_access && w_is_store) ? w_sdata : 32'h0;
   assign stallreq_o = w_access;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: drives on the falling edge, checks outputs 1ns later.
module tb_mem_access;

   localparam logic [7:0] ADD_OP = 8'b0010_0000;
   localparam logic [7:0] LB_OP  = 8'b1110_0000;
   localparam logic [7:0] LBU_OP = 8'b1110_0100;
   localparam logic [7:0] LH_OP  = 8'b1110_0001;
   localparam logic [7:0] LHU_OP = 8'b1110_0101;
   localparam logic [7:0] LW_OP  = 8'b1110_0011;
   localparam logic [7:0] SH_OP  = 8'b1110_1001;
   localparam logic [7:0] SB_OP  = 8'b1110_1000;
   localparam logic [7:0] SW_OP  = 8'b1110_1011;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  wd_i;
   logic        wreg_i;
   logic [31:0] wdata_i;
   logic [31:0] hi_i;
   logic [31:0] lo_i;
   logic        whilo_i;
   logic [7:0]  aluop_i;
   logic [31:0] mem_addr_i;
   logic [31:0] reg2_i;
   logic [4:0]  wd_o;
   logic        wreg_o;
   logic [31:0] wdata_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;
   logic        whilo_o;
   logic        mem_ce_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [3:0]  mem_sel_o;
   logic [31:0] mem_data_o;
   logic [31:0] mem_data_i;
   logic        mem_ack_i;
   logic        stallreq_o;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_access dut (
      .clk(clk), .rst(rst),
      .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
      .hi_i(hi_i), .lo_i(lo_i), .whilo_i(whilo_i),
      .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
      .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
      .hi_o(hi_o), .lo_o(lo_o), .whilo_o(whilo_o),
      .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_sel_o(mem_sel_o), .mem_data_o(mem_data_o),
      .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i), .stallreq_o(stallreq_o)
   );

   task automatic drive(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] r2,
                        input logic [31:0] rdat, input logic ack);
      aluop_i    = op;
      mem_addr_i = addr;
      reg2_i     = r2;
      mem_data_i = rdat;
      mem_ack_i  = ack;
   endtask

   task automatic next_cycle();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; wd_i = 5'd0; wreg_i = 1'b0; wdata_i = 32'h0;
      hi_i = 32'h0; lo_i = 32'h0; whilo_i = 1'b0;
      drive(ADD_OP, 32'h0, 32'h0, 32'h0, 1'b0);
      next_cycle(); next_cycle();
      rst = 1'b0;
      #1;
      n_vec++; if (mem_ce_o !== 1'b0) begin n_err++; $display("FAIL reset_ce: got %b want 0", mem_ce_o); end
      n_vec++; if (stallreq_o !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stallreq_o); end
      n_vec++; if (mem_sel_o !== 4'b0000) begin n_err++; $display("FAIL reset_sel: got %b want 0000", mem_sel_o); end
   endtask

   task automatic test_passthrough();
      next_cycle();
      wd_i = 5'd5; wreg_i = 1'b1; wdata_i = 32'h1234; whilo_i = 1'b1;
      hi_i = 32'hAAAA_0001; lo_i = 32'h5555_0002;
      drive(ADD_OP, 32'h0000_1234, 32'h0, 32'h0, 1'b1);
      #1;
      n_vec++; if (wd_o !== 5'd5) begin n_err++; $display("FAIL pass_wd: got %0d want 5", wd_o); end
      n_vec++; if (wreg_o !== 1'b1) begin n_err++; $display("FAIL pass_wreg: got %b want 1", wreg_o); end
      n_vec++; if (wdata_o !== 32'h1234) begin n_err++; $display("FAIL pass_wdata: got %h want 00001234", wdata_o); end
      n_vec++; if (whilo_o !== 1'b1) begin n_err++; $display("FAIL pass_whilo: got %b want 1", whilo_o); end
      n_vec++; if (hi_o !== 32'hAAAA_0001 || lo_o !== 32'h5555_0002) begin n_err++; $display("FAIL pass_hilo: got %h/%h want aaaa0001/55550002", hi_o, lo_o); end
      n_vec++; if (mem_ce_o !== 1'b0 || stallreq_o !== 1'b0) begin n_err++; $display("FAIL pass_bus: ce=%b stall=%b want 0/0", mem_ce_o, stallreq_o); end
      mem_ack_i = 1'b0;
   endtask

   task automatic test_lb();
      next_cycle();
      wreg_i = 1'b1; whilo_i = 1'b1; wdata_i = 32'hDEAD_0000;
      drive(LB_OP, 32'h0000_1001, 32'h0, 32'h11F0_3344, 1'b1);
      #1;
      n_vec++; if (mem_addr_o !== 32'h0000_1000) begin n_err++; $display("FAIL lb_addr: got %h want 00001000", mem_addr_o); end
      n_vec++; if (mem_sel_o !== 4'b0100) begin n_err++; $display("FAIL lb_sel: got %b want 0100", mem_sel_o); end
      n_vec++; if (stallreq_o !== 1'b1 || mem_ce_o !== 1'b1 || mem_we_o !== 1'b0) begin n_err++; $display("FAIL lb_req: stall=%b ce=%b we=%b want 1/1/0", stallreq_o, mem_ce_o, mem_we_o); end
      n_vec++; if (wreg_o !== 1'b0 || whilo_o !== 1'b0) begin n_err++; $display("FAIL lb_mask: wreg=%b whilo=%b want 0/0", wreg_o, whilo_o); end
      next_cycle();
      mem_ack_i = 1'b0; mem_data_i = 32'h0;
      #1;
      n_vec++; if (wdata_o !== 32'hFFFF_FFF0) begin n_err++; $display("FAIL lb_data: got %h want fffffff0", wdata_o); end
      n_vec++; if (wreg_o !== 1'b1 || whilo_o !== 1'b1) begin n_err++; $display("FAIL lb_done_wreg: wreg=%b whilo=%b want 1/1", wreg_o, whilo_o); end
      n_vec++; if (stallreq_o !== 1'b0 || mem_ce_o !== 1'b0) begin n_err++; $display("FAIL lb_done_bus: stall=%b ce=%b want 0/0", stallreq_o, mem_ce_o); end
      next_cycle();
      drive(ADD_OP, 32'h0, 32'h0, 32'h0, 1'b0);
   endtask

   task automatic test_lhu_wait();
      next_cycle();
      whilo_i = 1'b0;
      drive(LHU_OP, 32'h0000_2002, 32'h0, 32'hAAAA_8001, 1'b0);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) next_cycle();
         mem_ack_i = (i == 3);
         #1;
         n_vec++; if (stallreq_o !== 1'b1 || mem_sel_o !== 4'b0011 || mem_addr_o !== 32'h0000_2000) begin n_err++; $display("FAIL lhu_wait%0d: stall=%b sel=%b addr=%h want 1/0011/00002000", i, stallreq_o, mem_sel_o, mem_addr_o); end
      end
      next_cycle();
      mem_ack_i = 1'b0;
      #1;
      n_vec++; if (stallreq_o !== 1'b0) begin n_err++; $display("FAIL lhu_release: got %b want 0", stallreq_o); end
      n_vec++; if (wdata_o !== 32'h0000_8001) begin n_err++; $display("FAIL lhu_data: got %h want 00008001", wdata_o); end
      next_cycle();
      drive(ADD_OP, 32'h0, 32'h0, 32'h0, 1'b0);
   endtask

   task automatic test_sb();
      next_cycle();
      wreg_i = 1'b0; wdata_i = 32'h0000_3003;
      drive(SB_OP, 32'h0000_3003, 32'h0000_00AB, 32'h0, 1'b1);
      #1;
      n_vec++; if (mem_data_o !== 32'hABAB_ABAB) begin n_err++; $display("FAIL sb_data: got %h want abababab", mem_data_o); end
      n_vec++; if (mem_sel_o !== 4'b0001 || mem_we_o !== 1'b1 || mem_addr_o !== 32'h0000_3000) begin n_err++; $display("FAIL sb_ctl: sel=%b we=%b addr=%h want 0001/1/00003000", mem_sel_o, mem_we_o, mem_addr_o); end
      next_cycle();
      mem_ack_i = 1'b0;
      #1;
      n_vec++; if (mem_ce_o !== 1'b0 || mem_we_o !== 1'b0 || mem_data_o !== 32'h0 || mem_sel_o !== 4'b0) begin n_err++; $display("FAIL sb_done_bus: ce=%b we=%b data=%h sel=%b want all zero", mem_ce_o, mem_we_o, mem_data_o, mem_sel_o); end
      n_vec++; if (wdata_o !== 32'h0000_3003 || stallreq_o !== 1'b0) begin n_err++; $display("FAIL sb_done_wdata: wdata=%h stall=%b want 00003003/0", wdata_o, stallreq_o); end
      next_cycle();
      drive(ADD_OP, 32'h0, 32'h0, 32'h0, 1'b0);
   endtask

   task automatic test_sizes();
      next_cycle();
      drive(SH_OP, 32'h0000_5001, 32'h1234_BEEF, 32'h0, 1'b1);
      #1;
      n_vec++; if (mem_sel_o !== 4'b1100 || mem_data_o !== 32'hBEEF_BEEF) begin n_err++; $display("FAIL sh_lane: sel=%b data=%h want 1100/beefbeef", mem_sel_o, mem_data_o); end
      next_cycle(); mem_ack_i = 1'b0;
      next_cycle();
      wreg_i = 1'b1;
      drive(LH_OP, 32'h0000_5002, 32'h0, 32'h0000_9ABC, 1'b1);
      next_cycle(); mem_ack_i = 1'b0; #1;
      n_vec++; if (wdata_o !== 32'hFFFF_9ABC) begin n_err++; $display("FAIL lh_sext: got %h want ffff9abc", wdata_o); end
      next_cycle();
      drive(LBU_OP, 32'h0000_6003, 32'h0, 32'h1234_56F0, 1'b1);
      next_cycle(); mem_ack_i = 1'b0; #1;
      n_vec++; if (wdata_o !== 32'h0000_00F0) begin n_err++; $display("FAIL lbu_zext: got %h want 000000f0", wdata_o); end
      next_cycle();
      drive(LW_OP, 32'h0000_7003, 32'h0, 32'h0, 1'b0);
      #1;
      n_vec++; if (mem_sel_o !== 4'b1111 || mem_addr_o !== 32'h0000_7000) begin n_err++; $display("FAIL lw_align: sel=%b addr=%h want 1111/00007000", mem_sel_o, mem_addr_o); end
      mem_ack_i = 1'b1; mem_data_i = 32'h0;
      next_cycle(); mem_ack_i = 1'b0;
      next_cycle();
      drive(ADD_OP, 32'h0, 32'h0, 32'h0, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [3:0] stalls;
      next_cycle();
      drive(LW_OP, 32'h0000_4000, 32'h0, 32'h1234_5678, 1'b1);
      #1; stalls[3] = stallreq_o;
      next_cycle(); mem_ack_i = 1'b0;
      #1; stalls[2] = stallreq_o;
      n_vec++; if (wdata_o !== 32'h1234_5678) begin n_err++; $display("FAIL b2b_lw_data: got %h want 12345678", wdata_o); end
      next_cycle();
      drive(SW_OP, 32'h0000_4004, 32'hCAFE_BABE, 32'h0, 1'b1);
      #1; stalls[1] = stallreq_o;
      n_vec++; if (mem_ce_o !== 1'b1 || mem_we_o !== 1'b1 || mem_data_o !== 32'hCAFE_BABE || mem_addr_o !== 32'h0000_4004) begin n_err++; $display("FAIL b2b_sw_req: ce=%b we=%b data=%h addr=%h want 1/1/cafebabe/00004004", mem_ce_o, mem_we_o, mem_data_o, mem_addr_o); end
      next_cycle(); mem_ack_i = 1'b0;
      #1; stalls[0] = stallreq_o;
      n_vec++; if (stalls !== 4'b1010) begin n_err++; $display("FAIL b2b_stall_pattern: got %b want 1010", stalls); end
      next_cycle();
      drive(ADD_OP, 32'h0, 32'h0, 32'h0, 1'b0);
   endtask

   task automatic test_reset_busy();
      next_cycle();
      drive(LW_OP, 32'h0000_8000, 32'h0, 32'hFFFF_FFFF, 1'b0);
      next_cycle();
      #1;
      n_vec++; if (stallreq_o !== 1'b1) begin n_err++; $display("FAIL rb_busy: got %b want 1", stallreq_o); end
      rst = 1'b1;
      next_cycle();
      rst = 1'b0; aluop_i = ADD_OP;
      #1;
      n_vec++; if (mem_ce_o !== 1'b0 || stallreq_o !== 1'b0) begin n_err++; $display("FAIL rb_release: ce=%b stall=%b want 0/0", mem_ce_o, stallreq_o); end
      mem_ack_i = 1'b1;
      next_cycle();
      drive(LW_OP, 32'h0000_8000, 32'h0, 32'hFFFF_FFFF, 1'b0);
      #1;
      n_vec++; if (stallreq_o !== 1'b1 || wreg_o !== 1'b0) begin n_err++; $display("FAIL rb_stray_ack: stall=%b wreg=%b want 1/0", stallreq_o, wreg_o); end
      next_cycle();
      #1;
      n_vec++; if (stallreq_o !== 1'b1) begin n_err++; $display("FAIL rb_still_busy: got %b want 1", stallreq_o); end
      mem_ack_i = 1'b1;
      next_cycle(); mem_ack_i = 1'b0;
      next_cycle();
      drive(ADD_OP, 32'h0, 32'h0, 32'h0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_lb();
      test_lhu_wait();
      test_sb();
      test_sizes();
      test_back_to_back();
      test_reset_busy();
      next_cycle();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
